// File: rtl/shifter_pkg.sv
// Shared definitions for the sequential shifter: operation encodings and FSM states.
package shifter_pkg;

    typedef enum logic [2:0] {
        MODE_PASS = 3'b000,
        MODE_LSL  = 3'b001,
        MODE_LSR  = 3'b010,
        MODE_ASR  = 3'b011,
        MODE_ROR  = 3'b100
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Encodings 101-111 behave as pass, so only these four ever enter SHIFT.
    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m == MODE_LSL) || (m == MODE_LSR) || (m == MODE_ASR) || (m == MODE_ROR);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single step: shifts data by n positions under the given mode.
module shift_step
    import shifter_pkg::*;
#(
    parameter int K = 16
) (
    input  logic [K-1:0]         data,
    input  logic [2:0]           mode,
    input  logic [$clog2(K)-1:0] n,
    output logic [K-1:0]         result
);

    // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        result = data;
        case (mode)
            MODE_LSL: result = data << n;
            MODE_LSR: result = data >> n;
            MODE_ASR: result = $signed(data) >>> n;
            MODE_ROR: result = (data >> n) | (data << (K - int'(n)));
            default:  result = data;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle barrel-less shifter: moves at most STEP bit positions per clock
// until the captured shift distance is consumed, then pulses done for one cycle.
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int K    = 16,
    parameter int STEP = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [K-1:0]         in,
    input  logic [2:0]           mode,
    input  logic [$clog2(K)-1:0] amt,
    output logic [K-1:0]         out,
    output logic                 busy,
    output logic                 done
);

    localparam int AW = $clog2(K);
    localparam logic [AW-1:0] STEP_W = AW'(STEP);

    generate
        if ((K < 4) || ((K & (K - 1)) != 0) || (STEP < 1) || (STEP > K - 1)) begin : g_bad_params
            $error("seq_shifter: K must be a power of two >= 4 and STEP within 1..K-1");
        end
    endgenerate

    state_e          r_state;
    state_e          w_next;
    logic [K-1:0]    r_out;
    logic [AW-1:0]   r_rem;
    logic [2:0]      r_mode;
    logic [AW-1:0]   w_n;
    logic [AW-1:0]   w_rem_next;
    logic [K-1:0]    w_step;
    logic            w_accept;

    // abort outranks a simultaneous start.
    assign w_accept   = (r_state == IDLE) && start && !abort;
    assign w_n        = (r_rem > STEP_W) ? STEP_W : r_rem;
    assign w_rem_next = r_rem - w_n;

    shift_step #(.K(K)) u_step (
        .data   (r_out),
        .mode   (r_mode),
        .n      (w_n),
        .result (w_step)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept)
                    w_next = (is_shift_mode(mode) && (amt != '0)) ? SHIFT : DONE;
            end
            SHIFT: begin
                if (abort)                   w_next = IDLE;
                else if (w_rem_next == '0)   w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out  <= '0;
            r_rem  <= '0;
            r_mode <= MODE_PASS;
        end else if (w_accept) begin
            r_out  <= in;
            r_rem  <= amt;
            r_mode <= mode;
        end else if ((r_state == SHIFT) && !abort) begin
            r_out  <= w_step;
            r_rem  <= w_rem_next;
        end
    end

    assign out  = r_out;
    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench: two shifter instances (STEP=1 and STEP=4) driven in
// lockstep and compared against a repeated single-step reference model.
module tb_seq_shifter;

    localparam int K = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [K-1:0]  in_d = '0;
    logic [2:0]    mode = '0;
    logic [3:0]    amt = '0;
    logic [K-1:0]  out1, out4;
    logic          busy1, busy4, done1, done4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_shifter #(.K(K), .STEP(1)) u_s1 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .in(in_d),
        .mode(mode), .amt(amt), .out(out1), .busy(busy1), .done(done1)
    );

    seq_shifter #(.K(K), .STEP(4)) u_s4 (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .in(in_d),
        .mode(mode), .amt(amt), .out(out4), .busy(busy4), .done(done4)
    );

    // Reference: apply the one-position operation amt times.
    function automatic logic [K-1:0] ref_op(input logic [K-1:0] x, input logic [2:0] m, input int a);
        logic [K-1:0] v = x;
        for (int i = 0; i < a; i++) begin
            case (m)
                3'd1:    v = {v[K-2:0], 1'b0};
                3'd2:    v = {1'b0, v[K-1:1]};
                3'd3:    v = {v[K-1], v[K-1:1]};
                3'd4:    v = {v[0], v[K-1:1]};
                default: v = v;
            endcase
        end
        return v;
    endfunction

    function automatic int ref_lat(input logic [2:0] m, input int a, input int step);
        if ((m >= 3'd1) && (m <= 3'd4) && (a != 0)) return 1 + (a + step - 1) / step;
        return 1;
    endfunction

    // One operation on both instances; with junk=1 a conflicting start is
    // held high while both are busy (SHIFT and the faster one's DONE).
    task automatic run_op(input string name, input logic [K-1:0] x, input logic [2:0] m,
                          input logic [3:0] a, input bit junk);
        logic [K-1:0] exp_v, r1, r4;
        int e1, e4, lat1, lat4, n1, n4;
        exp_v = ref_op(x, m, int'(a));
        e1 = ref_lat(m, int'(a), 1);
        e4 = ref_lat(m, int'(a), 4);
        lat1 = 0; lat4 = 0; n1 = 0; n4 = 0; r1 = '0; r4 = '0;
        @(negedge clk);
        in_d = x; mode = m; amt = a; start = 1'b1;
        for (int c = 1; c <= e1 + 3; c++) begin
            @(posedge clk);
            #1;
            if (done1) begin n1++; if (lat1 == 0) begin lat1 = c; r1 = out1; end end
            if (done4) begin n4++; if (lat4 == 0) begin lat4 = c; r4 = out4; end end
            in_d = K'($urandom); mode = 3'($urandom); amt = 4'($urandom);
            start = junk && (c <= e4);
        end
        start = 1'b0;
        n_checks += 8;
        if (lat1 !== e1) $display("FAIL %s s1 latency: got %0d expected %0d", name, lat1, e1); else n_pass++;
        if (lat4 !== e4) $display("FAIL %s s4 latency: got %0d expected %0d", name, lat4, e4); else n_pass++;
        if (r1 !== exp_v) $display("FAIL %s s1 result: got %h expected %h", name, r1, exp_v); else n_pass++;
        if (r4 !== exp_v) $display("FAIL %s s4 result: got %h expected %h", name, r4, exp_v); else n_pass++;
        if (n1 !== 1) $display("FAIL %s s1 done pulses: got %0d expected 1", name, n1); else n_pass++;
        if (n4 !== 1) $display("FAIL %s s4 done pulses: got %0d expected 1", name, n4); else n_pass++;
        if (out1 !== exp_v) $display("FAIL %s s1 held out: got %h expected %h", name, out1, exp_v); else n_pass++;
        if (out4 !== exp_v) $display("FAIL %s s4 held out: got %h expected %h", name, out4, exp_v); else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_checks++;
        if ({out1, out4, busy1, busy4, done1, done4} !== '0)
            $display("FAIL reset_state: got out1=%h out4=%h busy=%b%b done=%b%b expected all 0",
                     out1, out4, busy1, busy4, done1, done4);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        run_op("lsl_8001_3", 16'h8001, 3'd1, 4'd3, 1'b0);
        run_op("asr_8000_4", 16'h8000, 3'd3, 4'd4, 1'b0);
        run_op("lsr_8000_4", 16'h8000, 3'd2, 4'd4, 1'b0);
        run_op("ror_0001_5", 16'h0001, 3'd4, 4'd5, 1'b0);
        run_op("ror_0001_0", 16'h0001, 3'd4, 4'd0, 1'b0);
        run_op("pass_amt5",  16'h1234, 3'd0, 4'd5, 1'b0);
        run_op("mode7_amt3", 16'hBEEF, 3'd7, 4'd3, 1'b0);
        run_op("lsl_amt15",  16'hFFFF, 3'd1, 4'd15, 1'b0);
        run_op("asr_amt15",  16'h8000, 3'd3, 4'd15, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_op("ignore_start_ror", 16'hA5C3, 3'd4, 4'd9, 1'b1);
        run_op("ignore_start_lsl", 16'h8001, 3'd1, 4'd3, 1'b1);
    endtask

    task automatic test_abort();
        int n1 = 0, n4 = 0;
        @(negedge clk);
        in_d = K'($urandom); mode = 3'd1; amt = 4'd7; start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (done1) n1++;
            if (done4) n4++;
            start = 1'b0;
            if (c == 3) begin
                n_checks += 2;
                if (busy1 !== 1'b0) $display("FAIL abort s1 busy: got %b expected 0", busy1); else n_pass++;
                if (busy4 !== 1'b0) $display("FAIL abort s4 busy: got %b expected 0", busy4); else n_pass++;
            end
            abort = (c == 2);
        end
        n_checks += 2;
        if (n1 !== 0) $display("FAIL abort s1 done pulses: got %0d expected 0", n1); else n_pass++;
        if (n4 !== 0) $display("FAIL abort s4 done pulses: got %0d expected 0", n4); else n_pass++;
        run_op("after_abort", 16'h0F0F, 3'd2, 4'd6, 1'b0);
    endtask

    task automatic test_mid_reset();
        int n1 = 0, n4 = 0;
        @(negedge clk);
        in_d = 16'hFFFF; mode = 3'd1; amt = 4'd7; start = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({out1, out4, busy1, busy4, done1, done4} !== '0)
            $display("FAIL mid_reset outputs: got out1=%h out4=%h busy=%b%b done=%b%b expected all 0",
                     out1, out4, busy1, busy4, done1, done4);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (done1) n1++;
            if (done4) n4++;
        end
        n_checks++;
        if ((n1 + n4) !== 0) $display("FAIL mid_reset done pulses: got %0d expected 0", n1 + n4); else n_pass++;
        run_op("after_reset", 16'h8001, 3'd1, 4'd3, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            run_op("random", K'($urandom), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_abort();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The block SHALL have parameter K, default 16, data width in bits; legal values are powers of two, 4 or more.
REQ-002 The block SHALL have parameter STEP, default 1, maximum bit positions shifted per clock; legal range is 1..K-1.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 The block SHALL have port abort  input  1  synchronous cancel of an operation in progress.
REQ-007 The block SHALL have port in  input  K  operand, captured on an accepted start.
REQ-008 The block SHALL have port mode  input  3  operation, captured on an accepted start: 000 pass, 001 LSL, 010 LSR, 011 ASR, 100 ROR; 101-111 are treated as pass.
REQ-009 The block SHALL have port amt  input  log2(K)  shift distance, captured on an accepted start.
REQ-010 The block SHALL have port out  output  K  registered result; valid while done=1 and held until the next accepted start.
REQ-011 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 The block SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have exactly three states:
- IDLE -> SHIFT on start when amt!=0 and mode is not pass.
- IDLE -> DONE on start when amt=0 or mode is pass.
- SHIFT -> DONE when the remaining count reaches 0.
- DONE -> IDLE unconditionally.
REQ-014 An accepted start SHALL load out<=in, load remaining<=amt, and latch mode and amt internally; later changes to the inputs SHALL have no effect on the operation.
REQ-015 Each clock edge in SHIFT SHALL shift out by n=min(STEP,remaining) positions under the latched mode and decrement remaining by n.
REQ-016 LSL SHALL zero-fill at the LSB.
REQ-017 LSR SHALL zero-fill at the MSB.
REQ-018 ASR SHALL fill vacated MSBs with the original bit K-1.
REQ-019 ROR SHALL feed bits shifted out of the LSB back into the MSB.
REQ-020 The result SHALL equal the single-step operation applied amt times, for every STEP.
REQ-021 done SHALL be 1 exactly during the DONE state; latency from the start-sampling edge to the done-high cycle SHALL be 1+ceil(amt/STEP) edges for shifting modes and 1 edge for pass or amt=0.
REQ-022 start while busy=1, including during DONE, SHALL be ignored without error.
REQ-023 abort=1 in SHIFT SHALL move the FSM to IDLE on the next edge with no done pulse; the partial value in out is undefined-by-contract.
REQ-024 abort in IDLE or DONE SHALL have no effect.
REQ-025 abort SHALL take priority over start in the same cycle.
REQ-026 out SHALL change only on an accepted start or in SHIFT; its intermediate values are not results.

Reset
REQ-027 While reset_n=0, asynchronously and independent of clk: state SHALL be IDLE, out=0, busy=0, done=0, and remaining=0.
REQ-028 Assertion of reset_n mid-operation SHALL discard that operation; no done pulse SHALL follow.
REQ-029 After reset_n deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled.

Structure
REQ-030 Package shifter_pkg SHALL hold the mode encodings (MODE_PASS, MODE_LSL, MODE_LSR, MODE_ASR, MODE_ROR) and the FSM state type (IDLE, SHIFT, DONE).
REQ-031 Combinational sub-module shift_step (data, mode, n -> result) SHALL implement one shift of 0..STEP positions; seq_shifter SHALL instantiate it once.
REQ-032 An elaboration-time check SHALL reject a K that is not a power of two, or a STEP outside 1..K-1.

Verification
REQ-033 For K=16, STEP=1: LSL with in=16'h8001, amt=3 SHALL raise done on the 4th edge after start with out=16'h0008.
REQ-034 For K=16, STEP=1: ASR with in=16'h8000, amt=4 SHALL produce out=16'hF800; LSR with the same operands SHALL produce out=16'h0800.
REQ-035 For K=16, STEP=4: ROR with in=16'h0001, amt=5 SHALL raise done on the 3rd edge with out=16'h0800; with amt=0, done SHALL rise on the 1st edge with out=16'h0001.
REQ-036 For K=16, STEP=1: a second start with different operands during SHIFT and during DONE SHALL be ignored; the first operation's result and timing SHALL be unchanged.
REQ-037 For K=16, STEP=1: abort on the 2nd SHIFT cycle of LSL amt=7 SHALL give busy=0 on the next edge, no done pulse, and acceptance of the next start.
REQ-038 For K=16, STEP=1: reset_n pulsed low mid-SHIFT SHALL immediately force out=0, busy=0, done=0, with no later done pulse.
